md_scheduler: RTL and testbench
===============================

MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, the busy duration of mult/multu in cycles (legal 1..15).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, the busy duration of div/divu in cycles (legal 1..15).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_E  input  1  E-stage instruction is a multiply/divide-unit op this cycle.
REQ-006 md_op_E  input  3  op code: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op.
REQ-007 A_E  input  32  forwarded rs operand (dividend/multiplicand/mthi-mtlo source).
REQ-008 B_E  input  32  forwarded rt operand (divisor/multiplier).
REQ-009 md_use_D  input  1  D-stage instruction is mult, multu, div, divu, mfhi, mflo, mthi or mtlo.
REQ-010 hi_out  output  32  architectural HI register.
REQ-011 lo_out  output  32  architectural LO register.
REQ-012 busy  output  1  registered; high while a mult/div operation is in flight.
REQ-013 stall_D  output  1  combinational stall request to the D stage.

Function
REQ-014 The block SHALL implement a two-state machine IDLE/BUSY with a 4-bit down counter cnt and latched pending HI/LO result registers.
REQ-015 IDLE, start_E=1, md_op_E in {000..011}: operands SHALL be captured and the result computed, cnt loaded with MULT_CYCLES or DIV_CYCLES, next state BUSY.
REQ-016 BUSY: cnt SHALL decrement by 1 each cycle; at the edge where cnt==1, pending HI/LO SHALL be written to hi_out/lo_out and state SHALL return to IDLE.
REQ-017 Latency: start_E sampled at edge t, busy SHALL be high for exactly N cycles after t, and new hi_out/lo_out SHALL be visible after edge t+N (N = MULT_CYCLES or DIV_CYCLES).
REQ-018 mult: {HI,LO} SHALL be the signed 64-bit product; multu: the unsigned 64-bit product.
REQ-019 div: LO SHALL be the signed quotient truncated toward zero, HI the remainder carrying the dividend's sign; divu: unsigned quotient/remainder.
REQ-020 Divide by zero SHALL still occupy DIV_CYCLES of busy and SHALL leave HI and LO unchanged.
REQ-021 div 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-022 mthi/mtlo in IDLE SHALL write A_E to HI/LO at that edge, with no busy period.
REQ-023 start_E while busy=1 SHALL be ignored (state, cnt, HI, LO unchanged).
REQ-024 stall_D SHALL equal md_use_D & (busy | (start_E & md_op_E in {000..011})).
REQ-025 md_op_E codes 110/111 with start_E=1 SHALL have no effect.
REQ-026 The cycle busy falls, stall_D SHALL deassert and mfhi/mflo in D SHALL see the new value.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, cnt=0, busy=0, hi_out=0, lo_out=0, pending results=0, regardless of clk.
REQ-028 reset asserted mid-operation SHALL abandon the operation; no HI/LO write SHALL occur after reset release.
REQ-029 After reset release, the first start_E SHALL be accepted normally.

Verification
REQ-030 mult A=0xFFFFFFFD, B=7 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-031 multu A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; with md_use_D=1 throughout, stall_D high in start cycle plus 5 busy cycles, low thereafter.
REQ-032 div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
REQ-033 mthi A=0x12345678 in IDLE -> HI=0x12345678 next edge, busy stays 0; mtlo issued during busy -> ignored.
REQ-034 Second mult start_E at busy cycle 2 -> ignored, only first result written, busy falls at original cycle.
REQ-035 reset pulsed at busy cycle 3 of div, between clock edges -> busy, hi_out, lo_out go 0 immediately, stay 0 after counter would have expired.

Source files
------------

// File: rtl/md_scheduler_if.sv
// md_scheduler_if: E/D-stage request signals and HI/LO/stall results of the multiply/divide unit
interface md_scheduler_if;
  logic start_E;
  logic [2:0] md_op_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic md_use_D;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic busy;
  logic stall_D;
  modport master (output start_E, md_op_E, A_E, B_E, md_use_D, input hi_out, lo_out, busy, stall_D);
  modport slave (input start_E, md_op_E, A_E, B_E, md_use_D, output hi_out, lo_out, busy, stall_D);
endinterface

// File: rtl/md_scheduler.sv
// md_scheduler: multicycle multiply/divide unit with HI/LO registers and D-stage stall
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  md_scheduler_if.slave md
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] pend_hi, pend_lo, hi, lo;
  logic is_md, go, done, a_neg, b_neg;
  logic [31:0] ua, ub, uq, ur, q, r;
  logic [63:0] prod;
  assign is_md = md.start_E & ~md.md_op_E[2];
  assign go = state == IDLE && is_md;
  assign done = state == BUSY && cnt == 4'd1;
  assign a_neg = ~md.md_op_E[0] & md.A_E[31];
  assign b_neg = ~md.md_op_E[0] & md.B_E[31];
  assign prod = {{32{a_neg}}, md.A_E} * {{32{b_neg}}, md.B_E};
  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly
  assign ua = a_neg ? -md.A_E : md.A_E;
  assign ub = b_neg ? -md.B_E : md.B_E;
  assign uq = ub == 32'd0 ? 32'd0 : ua / ub;
  assign ur = ub == 32'd0 ? 32'd0 : ua % ub;
  assign q = a_neg ^ b_neg ? -uq : uq;
  assign r = a_neg ? -ur : ur;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = go ? BUSY : done ? IDLE : state;
  always_comb begin
    md.busy = state == BUSY;
    md.stall_D = md.md_use_D & (state == BUSY | is_md);
    md.hi_out = hi;
    md.lo_out = lo;
  end
  // Divide by zero latches the current HI/LO so the writeback leaves them unchanged
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (go) begin
      cnt <= md.md_op_E[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      {pend_hi, pend_lo} <= !md.md_op_E[1] ? prod : md.B_E == 32'd0 ? {hi, lo} : {r, q};
    end else if (state == BUSY) begin
      cnt <= cnt - 4'd1;
      if (done) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (md.start_E && md.md_op_E == 3'b100) hi <= md.A_E;
    else if (md.start_E && md.md_op_E == 3'b101) lo <= md.A_E;
endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed and random stimulus checked against a cycle-level HI/LO reference model
module tb_md_scheduler;
  localparam int MC = 5, DC = 10;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0, n_err = 0;
  int m_rem;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  md_scheduler_if md();
  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(md));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    logic [63:0] p;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (s) begin
      x = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
      y = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
      if (op < 3'd2) begin
        p = 64'(x * y);
        {m_phi, m_plo} = p;
        m_rem = MC;
      end else if (op < 3'd4) begin
        m_rem = DC;
        if (y == 0) {m_phi, m_plo} = {m_hi, m_lo};
        else {m_phi, m_plo} = {32'(x % y), 32'(x / y)};
      end else if (op == 3'd4) m_hi = a;
      else if (op == 3'd5) m_lo = a;
    end
  endtask

  task automatic cyc(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic u);
    @(negedge clk);
    md.start_E = s;
    md.md_op_E = op;
    md.A_E = a;
    md.B_E = b;
    md.md_use_D = u;
    #1;
    chk("stall_D", {31'b0, md.stall_D}, {31'b0, u & (m_rem > 0 || (s && op < 3'd4))});
    @(posedge clk);
    model_edge(s, op, a, b);
    #1;
    chk("busy", {31'b0, md.busy}, {31'b0, m_rem > 0});
    chk("hi", md.hi_out, m_hi);
    chk("lo", md.lo_out, m_lo);
  endtask

  task automatic idle(input int n, input logic u);
    repeat (n) cyc(1'b0, 3'd0, 32'd0, 32'd0, u);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 7);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_rem = 0;
    m_hi = 0;
    m_lo = 0;
    m_phi = 0;
    m_plo = 0;
    reset = 1'b1;
    md.start_E = 1'b0;
    md.md_op_E = 3'd0;
    md.A_E = 32'd0;
    md.B_E = 32'd0;
    md.md_use_D = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, md.busy}, 32'd0);
    chk("rst_hi", md.hi_out, 32'd0);
    chk("rst_lo", md.lo_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b1);
    chk("mthi", md.hi_out, 32'h1234_5678);
    cyc(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    idle(MC, 1'b0);
    chk("mult_hi", md.hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", md.lo_out, 32'hFFFF_FFEB);
    cyc(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    idle(MC + 1, 1'b1);
    chk("multu_hi", md.hi_out, 32'h0000_0001);
    chk("multu_lo", md.lo_out, 32'hFFFF_FFFE);
    cyc(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DC, 1'b0);
    chk("div_hi", md.hi_out, 32'hFFFF_FFFF);
    chk("div_lo", md.lo_out, 32'hFFFF_FFFD);
    cyc(1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
    idle(DC, 1'b0);
    chk("div0_hi", md.hi_out, 32'hFFFF_FFFF);
    chk("div0_lo", md.lo_out, 32'hFFFF_FFFD);
    cyc(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DC, 1'b0);
    chk("ovf_hi", md.hi_out, 32'h0000_0000);
    chk("ovf_lo", md.lo_out, 32'h8000_0000);
    cyc(1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
    idle(1, 1'b0);
    cyc(1'b1, 3'd0, 32'd100, 32'd100, 1'b1);
    cyc(1'b1, 3'd5, 32'hDEAD, 32'd0, 1'b0);
    idle(1, 1'b0);
    chk("second_busy", {31'b0, md.busy}, 32'd1);
    idle(1, 1'b0);
    chk("second_done", {31'b0, md.busy}, 32'd0);
    chk("second_lo", md.lo_out, 32'd12);
    cyc(1'b1, 3'd6, 32'hAAAA_AAAA, 32'd1, 1'b1);
    cyc(1'b1, 3'd7, 32'hAAAA_AAAA, 32'd1, 1'b1);
    chk("noop_lo", md.lo_out, 32'd12);
    cyc(1'b1, 3'd4, 32'h55, 32'd0, 1'b0);
    cyc(1'b1, 3'd2, 32'd50, 32'd7, 1'b0);
    idle(2, 1'b0);
    @(negedge clk);
    md.start_E = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, md.busy}, 32'd0);
    chk("mid_rst_hi", md.hi_out, 32'd0);
    chk("mid_rst_lo", md.lo_out, 32'd0);
    m_rem = 0;
    m_hi = 0;
    m_lo = 0;
    @(negedge clk);
    reset = 1'b0;
    idle(DC + 2, 1'b0);
    cyc(1'b1, 3'd1, 32'd6, 32'd7, 1'b1);
    idle(MC, 1'b0);
    chk("post_rst_lo", md.lo_out, 32'd42);
    repeat (1500) cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
